// File: rtl/ajuste_hora.sv
// Time-set controller: edits hour/min/sec/AmPm/format from push buttons,
// then issues a single write request to the RTC and holds off for the burst.
module ajuste_hora (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_prog,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  output logic [6:0] hora,
  output logic [7:0] min,
  output logic [7:0] seg,
  output logic       AmPm,
  output logic       form,
  output logic       chs,
  output logic       editando,
  output logic [2:0] campo
);

  // state | meaning
  // IDLE  | waiting for btn_prog
  // EDIT  | buttons modify the selected field
  // SEND  | one-cycle chs request to the RTC write sequencer
  // HOLD  | 255-cycle lockout while the register burst completes
  typedef enum logic [1:0] {IDLE, EDIT, SEND, HOLD} state_t;

  state_t     state;
  logic [7:0] hold_cnt;
  logic [4:0] btn_q;
  logic [4:0] btn_now;
  logic [4:0] ev;
  logic       ev_prog, ev_izq, ev_der, ev_arriba, ev_abajo;

  assign btn_now = {btn_prog, btn_izq, btn_der, btn_arriba, btn_abajo};
  assign ev      = btn_now & ~btn_q;

  // Only the highest-priority event of the cycle survives.
  always_comb begin
    ev_prog   = ev[4];
    ev_izq    = ev[3] & ~ev[4];
    ev_der    = ev[2] & ~|ev[4:3];
    ev_arriba = ev[1] & ~|ev[4:2];
    ev_abajo  = ev[0] & ~|ev[4:1];
  end

  function automatic logic [6:0] hora_up(input logic [6:0] v);
    if (v == 7'h12)          return 7'h01;
    else if (v[3:0] == 4'h9) return {v[6:4] + 3'd1, 4'h0};
    else                     return v + 7'd1;
  endfunction

  function automatic logic [6:0] hora_dn(input logic [6:0] v);
    if (v == 7'h01)          return 7'h12;
    else if (v[3:0] == 4'h0) return {v[6:4] - 3'd1, 4'h9};
    else                     return v - 7'd1;
  endfunction

  function automatic logic [7:0] bcd60_up(input logic [7:0] v);
    if (v[3:0] != 4'h9)      return v + 8'd1;
    else if (v[7:4] == 4'h5) return 8'h00;
    else                     return {v[7:4] + 4'd1, 4'h0};
  endfunction

  function automatic logic [7:0] bcd60_dn(input logic [7:0] v);
    if (v[3:0] != 4'h0)      return v - 8'd1;
    else if (v[7:4] == 4'h0) return 8'h59;
    else                     return {v[7:4] - 4'd1, 4'h9};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      btn_q    <= 5'd0;
      hora     <= 7'h12;
      min      <= 8'h00;
      seg      <= 8'h00;
      AmPm     <= 1'b0;
      form     <= 1'b0;
      chs      <= 1'b0;
      editando <= 1'b0;
      campo    <= 3'd0;
    end else begin
      btn_q <= btn_now;
      chs   <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_prog) begin
            state    <= EDIT;
            campo    <= 3'd0;
            editando <= 1'b1;
          end
        end
        EDIT: begin
          if (ev_prog) begin
            state    <= SEND;
            chs      <= 1'b1;
            editando <= 1'b0;
          end else if (ev_izq) begin
            campo <= (campo == 3'd0) ? 3'd4 : campo - 3'd1;
          end else if (ev_der) begin
            campo <= (campo == 3'd4) ? 3'd0 : campo + 3'd1;
          end else if (ev_arriba || ev_abajo) begin
            case (campo)
              3'd0:    hora <= ev_arriba ? hora_up(hora) : hora_dn(hora);
              3'd1:    min  <= ev_arriba ? bcd60_up(min) : bcd60_dn(min);
              3'd2:    seg  <= ev_arriba ? bcd60_up(seg) : bcd60_dn(seg);
              3'd3:    AmPm <= ~AmPm;
              3'd4:    form <= ~form;
              default: ;
            endcase
          end
        end
        SEND: begin
          state    <= HOLD;
          hold_cnt <= 8'hFF;
        end
        HOLD: begin
          // Loaded with 255 and left at the count of 1, giving 255 HOLD cycles.
          if (hold_cnt == 8'd1) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ajuste_hora.sv
// Directed bench for ajuste_hora: field editing, priority, send/hold timing
// and reset during HOLD, with hand-computed expectations.
module tb_ajuste_hora;

  logic       clock;
  logic       reset;
  logic [4:0] btns;   // {prog, izq, der, arriba, abajo}
  logic [6:0] hora;
  logic [7:0] minv;
  logic [7:0] seg;
  logic       AmPm, form, chs, editando;
  logic [2:0] campo;

  int n_total = 0;
  int n_pass  = 0;
  int chs_cnt = 0;
  int chs_base;

  localparam int B_PROG = 4, B_IZQ = 3, B_DER = 2, B_ARR = 1, B_ABA = 0;

  ajuste_hora dut (
    .clock      (clock),
    .reset      (reset),
    .btn_prog   (btns[4]),
    .btn_izq    (btns[3]),
    .btn_der    (btns[2]),
    .btn_arriba (btns[1]),
    .btn_abajo  (btns[0]),
    .hora       (hora),
    .min        (minv),
    .seg        (seg),
    .AmPm       (AmPm),
    .form       (form),
    .chs        (chs),
    .editando   (editando),
    .campo      (campo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (chs === 1'b1) chs_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; one event edge, then released so the next press is a new event.
  task automatic press(input int idx);
    btns[idx] = 1'b1;
    @(negedge clock);
    btns[idx] = 1'b0;
    @(negedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hora"}, 32'(hora), 32'h12);
    chk({tag, "_min"}, 32'(minv), 32'h00);
    chk({tag, "_seg"}, 32'(seg), 32'h00);
    chk({tag, "_ampm"}, 32'(AmPm), 32'h0);
    chk({tag, "_form"}, 32'(form), 32'h0);
    chk({tag, "_chs"}, 32'(chs), 32'h0);
    chk({tag, "_edit"}, 32'(editando), 32'h0);
    chk({tag, "_campo"}, 32'(campo), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    btns  = 5'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk_reset_vals("rst");
    repeat (10) @(negedge clock);
    chk("idle_hora", 32'(hora), 32'h12);
    chk("idle_chs_cnt", 32'(chs_cnt), 32'd0);

    // Hour editing: 12 -> 01 -> 12 -> 11
    press(B_PROG);
    chk("enter_edit", 32'(editando), 32'h1);
    chk("enter_campo", 32'(campo), 32'h0);
    press(B_ARR);
    chk("hora_up_wrap", 32'(hora), 32'h01);
    press(B_ABA);
    press(B_ABA);
    chk("hora_dn", 32'(hora), 32'h11);
    chk("hora_ampm", 32'(AmPm), 32'h0);

    // Minutes: 60 increments wrap back to 00, one decrement gives 59
    press(B_DER);
    chk("campo_min", 32'(campo), 32'h1);
    for (int i = 1; i <= 60; i++) begin
      press(B_ARR);
      if (i == 10) chk("min_carry", 32'(minv), 32'h10);
    end
    chk("min_wrap_up", 32'(minv), 32'h00);
    press(B_ABA);
    chk("min_wrap_dn", 32'(minv), 32'h59);
    chk("min_hora_kept", 32'(hora), 32'h11);

    press(B_DER);
    press(B_ABA);
    chk("seg_wrap_dn", 32'(seg), 32'h59);
    press(B_DER);
    press(B_ARR);
    chk("ampm_toggle", 32'(AmPm), 32'h1);
    press(B_DER);
    chk("campo_form", 32'(campo), 32'h4);
    press(B_ABA);
    chk("form_toggle", 32'(form), 32'h1);
    press(B_DER);
    chk("campo_wrap_fwd", 32'(campo), 32'h0);

    // A held button steps only once
    btns[B_DER] = 1'b1;
    repeat (5) @(negedge clock);
    btns[B_DER] = 1'b0;
    @(negedge clock);
    chk("held_once", 32'(campo), 32'h1);
    press(B_IZQ);
    chk("campo_back", 32'(campo), 32'h0);

    // izq beats arriba in the same cycle; arriba is discarded
    btns[B_IZQ] = 1'b1;
    btns[B_ARR] = 1'b1;
    @(negedge clock);
    btns[B_IZQ] = 1'b0;
    btns[B_ARR] = 1'b0;
    @(negedge clock);
    chk("prio_campo", 32'(campo), 32'h4);
    chk("prio_form", 32'(form), 32'h1);
    chk("prio_hora", 32'(hora), 32'h11);

    // Send 1: one chs pulse, events in HOLD ignored, including on the last HOLD cycle
    chs_base = chs_cnt;
    btns[B_PROG] = 1'b1;
    @(negedge clock);
    chk("send1_chs", 32'(chs), 32'h1);
    chk("send1_edit", 32'(editando), 32'h0);
    btns[B_PROG] = 1'b0;
    for (int n = 1; n <= 258; n++) begin
      @(negedge clock);
      if (n == 1) chk("send1_chs_off", 32'(chs), 32'h0);
      if (n == 10) begin btns[B_PROG] = 1'b1; btns[B_ARR] = 1'b1; end
      if (n == 11) begin
        btns[B_PROG] = 1'b0; btns[B_ARR] = 1'b0;
        chk("hold_ign_edit", 32'(editando), 32'h0);
      end
      if (n == 12) chk("hold_ign_hora", 32'(hora), 32'h11);
      if (n == 255) btns[B_PROG] = 1'b1;
      if (n == 256) begin
        btns[B_PROG] = 1'b0;
        chk("hold_last_ign", 32'(editando), 32'h0);
      end
      if (n == 257) btns[B_PROG] = 1'b1;
      if (n == 258) begin
        btns[B_PROG] = 1'b0;
        chk("reenter_edit", 32'(editando), 32'h1);
        chk("reenter_campo", 32'(campo), 32'h0);
      end
    end
    chk("send1_chs_count", 32'(chs_cnt - chs_base), 32'd1);

    // Set hora=07 and min=30
    for (int i = 0; i < 4; i++) press(B_ABA);
    chk("hora_10_to_07", 32'(hora), 32'h07);
    press(B_DER);
    for (int i = 0; i < 29; i++) press(B_ABA);
    chk("min_30", 32'(minv), 32'h30);

    // Send 2: a prog event on the first IDLE cycle after HOLD is accepted
    btns[B_PROG] = 1'b1;
    @(negedge clock);
    chk("send2_chs", 32'(chs), 32'h1);
    btns[B_PROG] = 1'b0;
    for (int n = 1; n <= 257; n++) begin
      @(negedge clock);
      if (n == 256) btns[B_PROG] = 1'b1;
      if (n == 257) begin
        btns[B_PROG] = 1'b0;
        chk("idle_first_cycle", 32'(editando), 32'h1);
      end
    end

    // Send 3, then reset 50 cycles into HOLD with prog held through reset release
    btns[B_PROG] = 1'b1;
    @(negedge clock);
    btns[B_PROG] = 1'b0;
    repeat (51) @(negedge clock);
    chk("frozen_hora", 32'(hora), 32'h07);
    chk("frozen_min", 32'(minv), 32'h30);
    reset = 1'b1;
    btns[B_PROG] = 1'b1;
    @(negedge clock);
    chk_reset_vals("hold_rst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("held_thru_reset", 32'(editando), 32'h1);
    btns[B_PROG] = 1'b0;
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ajuste_hora.md
AJUSTE_HORA -- requirements
Module: ajuste_hora

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below as name, direction, width and meaning.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_prog  input  1  debounced, clock-synchronous level; enters and leaves edit mode.
REQ-005 btn_izq  input  1  debounced level; selects the previous field.
REQ-006 btn_der  input  1  debounced level; selects the next field.
REQ-007 btn_arriba  input  1  debounced level; increments or toggles the current field.
REQ-008 btn_abajo  input  1  debounced level; decrements or toggles the current field.
REQ-009 hora  output  7  BCD hour, 12-hour range 0x01..0x12.
REQ-010 min  output  8  BCD minutes, 0x00..0x59.
REQ-011 seg  output  8  BCD seconds, 0x00..0x59.
REQ-012 AmPm  output  1  0=AM, 1=PM.
REQ-013 form  output  1  hour-format bit for the RTC control register.
REQ-014 chs  output  1  one-cycle request to the RTC write sequencer.
REQ-015 editando  output  1  high while in EDIT.
REQ-016 campo  output  3  selected field: 0=hora, 1=min, 2=seg, 3=AmPm, 4=form.

Function
REQ-017 Each button SHALL be registered once; an event SHALL be btn=1 while its registered copy=0.
- The action takes effect at that same clock edge.
- A held button produces one event only.
REQ-018 At most one action SHALL occur per cycle.
- Priority: btn_prog > btn_izq > btn_der > btn_arriba > btn_abajo.
- Events that lose priority are discarded and are not queued.
REQ-019 The FSM SHALL have four states: IDLE, EDIT, SEND, HOLD.
REQ-020 IDLE: a btn_prog event SHALL go to EDIT with campo=0; all other events are ignored.
REQ-021 EDIT, field selection: btn_der SHALL step campo 0->1->2->3->4->0; btn_izq steps the reverse direction, 0->4.
REQ-022 EDIT, hora field:
- btn_arriba steps 0x12->0x01, 0x09->0x10, otherwise +1.
- btn_abajo steps 0x01->0x12, 0x10->0x09, otherwise -1.
- Hour wrap SHALL NOT toggle AmPm.
REQ-023 EDIT, min and seg fields: BCD count with low nibble 0..9 carrying into the high nibble 0..5.
- Wrap 0x59->0x00 when counting up and 0x00->0x59 when counting down.
- The other fields SHALL be unaffected.
REQ-024 EDIT, AmPm and form fields: btn_arriba and btn_abajo SHALL each toggle the selected bit.
REQ-025 EDIT: a btn_prog event SHALL go to SEND; values are frozen from that edge.
REQ-026 SEND SHALL last exactly one cycle with chs=1, then go to HOLD.
REQ-027 HOLD SHALL last 255 cycles, counted by an 8-bit counter, then return to IDLE.
- All button events during HOLD are ignored.
- HOLD guarantees the downstream 5-register write burst completes before any further request.
REQ-028 chs SHALL be 0 in every state other than SEND.
REQ-029 hora, min, seg, AmPm and form SHALL be registered, and SHALL change only on EDIT actions or reset.
REQ-030 editando SHALL be 1 in EDIT only; campo SHALL hold its value outside EDIT and be reset to 0 on entry to EDIT.

Reset
REQ-031 On reset the outputs SHALL take these values: hora=0x12, min=0x00, seg=0x00, AmPm=0, form=0, chs=0, editando=0, campo=0.
REQ-032 On reset the internal state SHALL be: state=IDLE, HOLD counter=0, button registers=0.
REQ-033 Reset SHALL win over every other event, including reset asserted during SEND or HOLD; chs is 0 in the following cycle.
REQ-034 A button held high through reset release SHALL produce an event in the first cycle after reset, because its registered copy is 0.

Verification
REQ-035 Reset, then idle 10 cycles -> hora=0x12, min=0x00, seg=0x00, AmPm=0, chs never asserted.
REQ-036 btn_prog event, then btn_arriba event -> hora=0x01; then 2 btn_abajo events -> hora=0x11; AmPm stays 0.
REQ-037 btn_der event (campo=1), 60 btn_arriba events -> min passes 0x09->0x10 and 0x59->0x00, ending at 0x00; one btn_abajo event -> 0x59.
REQ-038 btn_izq and btn_arriba rising in the same cycle with campo=0 -> campo=4, form and hora unchanged.
REQ-039 btn_prog event in EDIT -> chs=1 for exactly one cycle (the cycle after the event edge); btn_prog and btn_arriba events within the next 255 cycles are ignored; editando=0; IDLE reached after HOLD.
REQ-040 Reset asserted 50 cycles into HOLD, with edited values hora=0x07, min=0x30 -> next cycle all outputs equal their REQ-031 reset values and chs=0.
